hazard_ctrl_unit: RTL and testbench



---
 rtl/hazard_ctrl_unit_if.sv | 54 +++++
 rtl/hazard_ctrl_unit.sv | 209 ++++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_if.sv
// ============================================================================
//  Module      : hazard_ctrl_unit_if
//  Description : Pipeline <-> hazard unit bundle. The pipeline (master)
//                presents ID/EX register info and forward-source state; the
//                hazard unit (slave) returns enables, bubbles and forward
//                selects.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_unit_if #(
  parameter int REG_AW  = 3,
  parameter int NUM_FWD = 3,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
);
  logic [REG_AW-1:0]         id_rs;
  logic [REG_AW-1:0]         id_rt;
  logic                      id_uses_rs;
  logic                      id_uses_rt;
  logic [REG_AW-1:0]         ex_rs;
  logic [REG_AW-1:0]         ex_rt;
  logic [REG_AW-1:0]         ex_rd;
  logic                      ex_mem_read;
  logic                      ex_multi;
  logic                      branch_taken;
  logic [NUM_FWD*REG_AW-1:0] fwd_rd;
  logic [NUM_FWD-1:0]        fwd_we;

  logic                      pc_write;
  logic                      ifid_write;
  logic                      ifid_flush;
  logic                      idex_write;
  logic                      idex_bubble;
  logic                      exmem_bubble;
  logic                      stall;
  logic [SEL_W-1:0]          fwd_sel_a;
  logic [SEL_W-1:0]          fwd_sel_b;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd,
           ex_mem_read, ex_multi, branch_taken, fwd_rd, fwd_we,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_bubble, stall, fwd_sel_a, fwd_sel_b
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd,
           ex_mem_read, ex_multi, branch_taken, fwd_rd, fwd_we,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_bubble, stall, fwd_sel_a, fwd_sel_b
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
// ============================================================================
//  Module      : hazard_ctrl_unit
//  Description : Pipeline hazard controller: N-source forwarding priority,
//                multi-cycle load-use stall, multi-cycle EX hold and
//                taken-branch flush, sequenced by a 3-state FSM.
//                Optional macro HAZ_PERF_CNT_EN adds saturating stall_cnt /
//                flush_cnt outputs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl_unit #(
  parameter int REG_AW   = 3,
  parameter int NUM_FWD  = 3,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int SEL_W    = $clog2(NUM_FWD + 1)
) (
  input  wire               clk,
  input  wire               rst_n,
  hazard_ctrl_unit_if.slave bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_LOAD  = CNT_W'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LD_WAIT = 2'd1;
  localparam logic [1:0] S_MULTI   = 2'd2;

  logic [1:0]         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               multi_done, done_nxt;
  logic [NUM_FWD-1:0] match_a, match_b;
  logic [SEL_W-1:0]   sel_a, sel_b;
  logic               lu, multi_req;
  logic               pc_write, ifid_write, ifid_flush;
  logic               idex_write, idex_bubble, exmem_bubble;

  // Per-source match flags; a source writing r0 never forwards.
  for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd_match
    logic [REG_AW-1:0] src_rd;
    assign src_rd     = bus.fwd_rd[k*REG_AW +: REG_AW];
    assign match_a[k] = bus.fwd_we[k] && (src_rd != '0) && (src_rd == bus.ex_rs);
    assign match_b[k] = bus.fwd_we[k] && (src_rd != '0) && (src_rd == bus.ex_rt);
  end

  // Priority pick: scanning oldest to youngest lets the youngest match win.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (match_a[k]) sel_a = SEL_W'(k + 1);
      if (match_b[k]) sel_b = SEL_W'(k + 1);
    end
  end

  assign lu = bus.ex_mem_read && (bus.ex_rd != '0) &&
              ((bus.id_uses_rs && (bus.ex_rd == bus.id_rs)) ||
               (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

  // The op still sits in EX during the cycle right after its hold ends, so
  // ex_multi is ignored for that one cycle to avoid re-holding the same op.
  assign multi_req = bus.ex_multi && !multi_done;

  // State register, countdown and post-hold marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= CNT_ZERO;
      multi_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      multi_done <= done_nxt;
    end
  end

  // Next-state logic. In MULTI, cnt holds the remaining MULTI cycles
  // (including the current one), so the total hold is MUL_LAT-1 cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.branch_taken) begin
          state_nxt = S_IDLE;
        end else if (multi_req) begin
          if (MUL_LAT > 2) begin
            state_nxt = S_MULTI;
            cnt_nxt   = MUL_LOAD;
          end else begin
            done_nxt  = 1'b1;
          end
        end else if (lu) begin
          if (LOAD_LAT > 1) begin
            state_nxt = S_LD_WAIT;
            cnt_nxt   = LD_LOAD;
          end
        end
      end
      S_LD_WAIT: begin
        if (bus.branch_taken || (cnt == CNT_ZERO)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt   = cnt - CNT_ONE;
        end
      end
      S_MULTI: begin
        if (cnt <= CNT_ONE) begin
          state_nxt = S_IDLE;
          cnt_nxt   = CNT_ZERO;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Control outputs; forced to defaults while reset is asserted.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (rst_n) begin
      case (state)
        S_IDLE: begin
          if (bus.branch_taken) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
          end else if (multi_req) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
          end else if (lu) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
          end
        end
        S_LD_WAIT: begin
          if (bus.branch_taken) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
          end else begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
          end
        end
        S_MULTI: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
        end
        default: begin
          pc_write     = 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_write   = idex_write;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_bubble = exmem_bubble;
  assign bus.stall        = ~pc_write;
  assign bus.fwd_sel_a    = rst_n ? sel_a : '0;
  assign bus.fwd_sel_b    = rst_n ? sel_b : '0;

`ifdef HAZ_PERF_CNT_EN
  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
// ============================================================================
//  Module      : tb_hazard_ctrl_unit
//  Description : Directed self-checking bench. Two DUTs share stimulus:
//                dut_a with LOAD_LAT=3, dut_b with LOAD_LAT=1 (both MUL_LAT=4).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl_unit;

  localparam int REG_AW  = 3;
  localparam int NUM_FWD = 3;
  localparam int SEL_W   = 2;

  // Packed control view: {pc_write, ifid_write, ifid_flush, idex_write,
  //                       idex_bubble, exmem_bubble, stall}
  localparam logic [6:0] C_DEF   = 7'b1101000;
  localparam logic [6:0] C_STALL = 7'b0001101;
  localparam logic [6:0] C_HOLD  = 7'b0000011;
  localparam logic [6:0] C_FLUSH = 7'b1111100;

  logic clk = 1'b0;
  logic rst_n;
  logic [REG_AW-1:0]         id_rs, id_rt, ex_rs, ex_rt, ex_rd;
  logic                      id_uses_rs, id_uses_rt, ex_mem_read, ex_multi, branch_taken;
  logic [NUM_FWD*REG_AW-1:0] fwd_rd;
  logic [NUM_FWD-1:0]        fwd_we;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) if_a ();
  hazard_ctrl_unit_if #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) if_b ();

  assign if_a.id_rs = id_rs;               assign if_b.id_rs = id_rs;
  assign if_a.id_rt = id_rt;               assign if_b.id_rt = id_rt;
  assign if_a.id_uses_rs = id_uses_rs;     assign if_b.id_uses_rs = id_uses_rs;
  assign if_a.id_uses_rt = id_uses_rt;     assign if_b.id_uses_rt = id_uses_rt;
  assign if_a.ex_rs = ex_rs;               assign if_b.ex_rs = ex_rs;
  assign if_a.ex_rt = ex_rt;               assign if_b.ex_rt = ex_rt;
  assign if_a.ex_rd = ex_rd;               assign if_b.ex_rd = ex_rd;
  assign if_a.ex_mem_read = ex_mem_read;   assign if_b.ex_mem_read = ex_mem_read;
  assign if_a.ex_multi = ex_multi;         assign if_b.ex_multi = ex_multi;
  assign if_a.branch_taken = branch_taken; assign if_b.branch_taken = branch_taken;
  assign if_a.fwd_rd = fwd_rd;             assign if_b.fwd_rd = fwd_rd;
  assign if_a.fwd_we = fwd_we;             assign if_b.fwd_we = fwd_we;

  logic [6:0] ctrl_a, ctrl_b;
  assign ctrl_a = {if_a.pc_write, if_a.ifid_write, if_a.ifid_flush, if_a.idex_write,
                   if_a.idex_bubble, if_a.exmem_bubble, if_a.stall};
  assign ctrl_b = {if_b.pc_write, if_b.ifid_write, if_b.ifid_flush, if_b.idex_write,
                   if_b.idex_bubble, if_b.exmem_bubble, if_b.stall};

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] sc_a, fc_a, sc_b, fc_b;
`endif

  hazard_ctrl_unit #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .LOAD_LAT(3), .MUL_LAT(4), .SEL_W(SEL_W)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt (sc_a), .flush_cnt (fc_a)
`endif
  );

  hazard_ctrl_unit #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .LOAD_LAT(1), .MUL_LAT(4), .SEL_W(SEL_W)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt (sc_b), .flush_cnt (fc_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_multi = 1'b0; branch_taken = 1'b0; fwd_rd = '0; fwd_we = '0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_rd = 3'd2; id_rs = 3'd2; id_uses_rs = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    set_lu();
    ex_multi = 1'b1; branch_taken = 1'b1;
    fwd_we = 3'b111; fwd_rd = 9'b011_011_011; ex_rs = 3'd3; ex_rt = 3'd3;
    #2;
    nvec++;
    if (ctrl_a !== C_DEF) begin nerr++; $display("FAIL reset_ctrl_a got %b expected %b", ctrl_a, C_DEF); end
    nvec++;
    if (ctrl_b !== C_DEF) begin nerr++; $display("FAIL reset_ctrl_b got %b expected %b", ctrl_b, C_DEF); end
    nvec++;
    if ({if_a.fwd_sel_a, if_a.fwd_sel_b} !== 4'b0000) begin
      nerr++; $display("FAIL reset_fwd_sel got %b expected 0000", {if_a.fwd_sel_a, if_a.fwd_sel_b});
    end
    clear_inputs();
    #1 rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    logic [2:0] we_t   [6] = '{3'b111, 3'b110, 3'b110, 3'b111, 3'b111, 3'b100};
    logic [8:0] rd_t   [6] = '{9'b011_011_011, 9'b011_011_011, 9'b011_000_011,
                               9'b000_000_000, 9'b101_110_111, 9'b101_110_111};
    logic [2:0] rs_t   [6] = '{3'd3, 3'd3, 3'd3, 3'd0, 3'd6, 3'd7};
    logic [2:0] rt_t   [6] = '{3'd0, 3'd3, 3'd3, 3'd0, 3'd5, 3'd5};
    logic [1:0] expa_t [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};
    logic [1:0] expb_t [6] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd3, 2'd3};
    tick();
    for (int v = 0; v < 6; v++) begin
      fwd_we = we_t[v]; fwd_rd = rd_t[v]; ex_rs = rs_t[v]; ex_rt = rt_t[v];
      #1;
      nvec++;
      if (if_a.fwd_sel_a !== expa_t[v]) begin
        nerr++; $display("FAIL fwd_sel_a vec %0d got %0d expected %0d", v, if_a.fwd_sel_a, expa_t[v]);
      end
      nvec++;
      if (if_a.fwd_sel_b !== expb_t[v]) begin
        nerr++; $display("FAIL fwd_sel_b vec %0d got %0d expected %0d", v, if_a.fwd_sel_b, expb_t[v]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    logic [6:0] exp_a [4] = '{C_STALL, C_STALL, C_STALL, C_DEF};
    logic [6:0] exp_b [4] = '{C_STALL, C_DEF, C_DEF, C_DEF};
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] s0;
    s0 = sc_a;
`endif
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) set_lu(); else clear_inputs();
      #1;
      nvec++;
      if (ctrl_a !== exp_a[c]) begin nerr++; $display("FAIL lu_lat3 cycle %0d got %b expected %b", c, ctrl_a, exp_a[c]); end
      nvec++;
      if (ctrl_b !== exp_b[c]) begin nerr++; $display("FAIL lu_lat1 cycle %0d got %b expected %b", c, ctrl_b, exp_b[c]); end
    end
`ifdef HAZ_PERF_CNT_EN
    nvec++;
    if (sc_a - s0 !== 32'd3) begin nerr++; $display("FAIL perf_stall_cnt got %0d expected 3", sc_a - s0); end
`endif
  endtask

  task automatic test_no_hazard();
    // Matching rd but the ID instruction does not read rs.
    tick();
    set_lu(); id_uses_rs = 1'b0;
    #1;
    nvec++;
    if (ctrl_a !== C_DEF) begin nerr++; $display("FAIL lu_unused_rs got %b expected %b", ctrl_a, C_DEF); end
    // Load into r0 never stalls.
    ex_rd = 3'd0; id_rs = 3'd0; id_uses_rs = 1'b1;
    #1;
    nvec++;
    if (ctrl_a !== C_DEF) begin nerr++; $display("FAIL lu_rd_zero got %b expected %b", ctrl_a, C_DEF); end
    // Hazard through rt.
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 3'd5; id_rt = 3'd5; id_uses_rt = 1'b1;
    #1;
    nvec++;
    if (ctrl_b !== C_STALL) begin nerr++; $display("FAIL lu_rt got %b expected %b", ctrl_b, C_STALL); end
    tick();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_multi();
    logic [6:0] exp_t [5] = '{C_HOLD, C_HOLD, C_HOLD, C_DEF, C_DEF};
    for (int c = 0; c < 5; c++) begin
      tick();
      clear_inputs();
      if (c < 4) ex_multi = 1'b1;
      if (c == 0) set_lu();
      if (c == 1) branch_taken = 1'b1;
      #1;
      nvec++;
      if (ctrl_a !== exp_t[c]) begin nerr++; $display("FAIL multi_a cycle %0d got %b expected %b", c, ctrl_a, exp_t[c]); end
      nvec++;
      if (ctrl_b !== exp_t[c]) begin nerr++; $display("FAIL multi_b cycle %0d got %b expected %b", c, ctrl_b, exp_t[c]); end
    end
    clear_inputs();
  endtask

  task automatic test_branch_ld_wait();
    logic [6:0] exp_a [3] = '{C_STALL, C_FLUSH, C_DEF};
    logic [6:0] exp_b [3] = '{C_STALL, C_FLUSH, C_DEF};
    for (int c = 0; c < 3; c++) begin
      tick();
      clear_inputs();
      if (c == 0) set_lu();
      if (c == 1) branch_taken = 1'b1;
      #1;
      nvec++;
      if (ctrl_a !== exp_a[c]) begin nerr++; $display("FAIL br_ldwait_a cycle %0d got %b expected %b", c, ctrl_a, exp_a[c]); end
      nvec++;
      if (ctrl_b !== exp_b[c]) begin nerr++; $display("FAIL br_ldwait_b cycle %0d got %b expected %b", c, ctrl_b, exp_b[c]); end
    end
  endtask

  task automatic test_branch_vs_lu();
    logic [6:0] exp_t [2] = '{C_FLUSH, C_DEF};
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] f0;
    f0 = fc_a;
`endif
    for (int c = 0; c < 2; c++) begin
      tick();
      clear_inputs();
      if (c == 0) begin set_lu(); branch_taken = 1'b1; end
      #1;
      nvec++;
      if (ctrl_a !== exp_t[c]) begin nerr++; $display("FAIL br_lu_a cycle %0d got %b expected %b", c, ctrl_a, exp_t[c]); end
    end
`ifdef HAZ_PERF_CNT_EN
    nvec++;
    if (fc_a - f0 !== 32'd1) begin nerr++; $display("FAIL perf_flush_cnt got %0d expected 1", fc_a - f0); end
`endif
  endtask

  task automatic test_reset_mid_multi();
    tick();
    ex_multi = 1'b1;
    #1;
    nvec++;
    if (ctrl_a !== C_HOLD) begin nerr++; $display("FAIL rstmul_hold1 got %b expected %b", ctrl_a, C_HOLD); end
    tick();
    #1;
    nvec++;
    if (ctrl_a !== C_HOLD) begin nerr++; $display("FAIL rstmul_hold2 got %b expected %b", ctrl_a, C_HOLD); end
    #1 rst_n = 1'b0;
    #1;
    nvec++;
    if (ctrl_a !== C_DEF) begin nerr++; $display("FAIL rstmul_async got %b expected %b", ctrl_a, C_DEF); end
    ex_multi = 1'b0;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      nvec++;
      if (ctrl_a !== C_DEF) begin nerr++; $display("FAIL rstmul_after cycle %0d got %b expected %b", c, ctrl_a, C_DEF); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_no_hazard();
    test_multi();
    test_branch_ld_wait();
    test_branch_vs_lu();
    test_reset_mid_multi();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
